// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester, reservation, query and write-port bundle
// Forwarding signals exist only when REGFILE_WB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_hold;
    logic              r0_valid;
    logic              r0_ready;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_data;
    logic              r1_valid;
    logic              r1_ready;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] q_a1;
    logic [ADDR_W-1:0] q_a2;
    logic              q_busy1;
    logic              q_busy2;
    logic              WE3;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
`ifdef REGFILE_WB_FWD_EN
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
`endif

    modport master (
        output wb_hold, r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
               rsv_valid, rsv_addr, q_a1, q_a2,
`ifdef REGFILE_WB_FWD_EN
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        input  r0_ready, r1_ready, q_busy1, q_busy2, WE3, A3, WD3
    );

    modport slave (
        input  wb_hold, r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
               rsv_valid, rsv_addr, q_a1, q_a2,
`ifdef REGFILE_WB_FWD_EN
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        output r0_ready, r1_ready, q_busy1, q_busy2, WE3, A3, WD3
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard
// Optional write-cycle operand forwarding enabled by REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;

    logic              rr_q, rr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              gnt0, gnt1;

    // rr_q=0 prefers req0; ready is gated by reset so nothing is accepted while squashed
    always_comb begin
        gnt0 = !rst && !bus.wb_hold && bus.r0_valid && (!bus.r1_valid || !rr_q);
        gnt1 = !rst && !bus.wb_hold && bus.r1_valid && (!bus.r0_valid || rr_q);
    end

    assign bus.r0_ready = gnt0;
    assign bus.r1_ready = gnt1;

    always_comb begin
        rr_d  = rr_q;
        we_d  = 1'b0;
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (gnt0) begin
            rr_d = 1'b1;
            if (bus.r0_addr != '0) begin
                we_d  = 1'b1;
                a3_d  = bus.r0_addr;
                wd3_d = bus.r0_data;
            end
        end else if (gnt1) begin
            rr_d = 1'b0;
            if (bus.r1_addr != '0) begin
                we_d  = 1'b1;
                a3_d  = bus.r1_addr;
                wd3_d = bus.r1_data;
            end
        end

        // Clear first so a same-edge reservation of the retiring register wins
        pend_d = pend_q;
        if (we_q) begin
            pend_d[a3_q] = 1'b0;
        end
        if (bus.rsv_valid) begin
            pend_d[bus.rsv_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= 1'b0;
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            pend_q <= '0;
        end else begin
            rr_q   <= rr_d;
            we_q   <= we_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            pend_q <= pend_d;
        end
    end

    assign bus.WE3 = we_q;
    assign bus.A3  = a3_q;
    assign bus.WD3 = wd3_q;

`ifdef REGFILE_WB_FWD_EN
    logic hit1, hit2;

    assign hit1 = we_q && (a3_q == bus.q_a1) && (bus.q_a1 != '0);
    assign hit2 = we_q && (a3_q == bus.q_a2) && (bus.q_a2 != '0);

    assign bus.fwd_hit1  = hit1;
    assign bus.fwd_hit2  = hit2;
    assign bus.fwd_data1 = wd3_q;
    assign bus.fwd_data2 = wd3_q;
    assign bus.q_busy1   = pend_q[bus.q_a1] && !hit1;
    assign bus.q_busy2   = pend_q[bus.q_a2] && !hit2;
`else
    assign bus.q_busy1 = pend_q[bus.q_a1];
    assign bus.q_busy2 = pend_q[bus.q_a2];
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef REGFILE_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: who is preferred, which registers await a write, what WE3 should show
    int          pref;
    bit [31:0]   pend;
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    bit          g0, g1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pref  = 0;
        pend  = '0;
        m_we  = 1'b0;
        m_a3  = '0;
        m_wd3 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_we3", {63'd0, bus.WE3}, 64'd0);
        chk("rst_a3", {59'd0, bus.A3}, 64'd0);
        chk("rst_wd3", {32'd0, bus.WD3}, 64'd0);
        chk("rst_rdy0", {63'd0, bus.r0_ready}, 64'd0);
        chk("rst_rdy1", {63'd0, bus.r1_ready}, 64'd0);
        chk("rst_busy1", {63'd0, bus.q_busy1}, 64'd0);
        chk("rst_busy2", {63'd0, bus.q_busy2}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: check combinational outputs against the model, clock, check the write port
    task automatic step();
        bit          fh1, fh2, rv;
        logic [4:0]  a0, a1, ra;
        logic [31:0] d0, d1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!bus.wb_hold) begin
            if (bus.r0_valid && bus.r1_valid) begin
                if (pref == 0) g0 = 1'b1; else g1 = 1'b1;
            end else if (bus.r0_valid) begin
                g0 = 1'b1;
            end else if (bus.r1_valid) begin
                g1 = 1'b1;
            end
        end
        fh1 = FWD && m_we && (m_a3 == bus.q_a1) && (bus.q_a1 != 0);
        fh2 = FWD && m_we && (m_a3 == bus.q_a2) && (bus.q_a2 != 0);
        chk("rdy0", {63'd0, bus.r0_ready}, {63'd0, g0});
        chk("rdy1", {63'd0, bus.r1_ready}, {63'd0, g1});
        chk("busy1", {63'd0, bus.q_busy1}, {63'd0, pend[bus.q_a1] && !fh1});
        chk("busy2", {63'd0, bus.q_busy2}, {63'd0, pend[bus.q_a2] && !fh2});
`ifdef REGFILE_WB_FWD_EN
        chk("fwd_hit1", {63'd0, bus.fwd_hit1}, {63'd0, fh1});
        chk("fwd_hit2", {63'd0, bus.fwd_hit2}, {63'd0, fh2});
        chk("fwd_data1", {32'd0, bus.fwd_data1}, {32'd0, m_wd3});
        chk("fwd_data2", {32'd0, bus.fwd_data2}, {32'd0, m_wd3});
`endif
        a0 = bus.r0_addr; d0 = bus.r0_data;
        a1 = bus.r1_addr; d1 = bus.r1_data;
        rv = bus.rsv_valid; ra = bus.rsv_addr;
        @(posedge clk);
        if (m_we) pend[m_a3] = 1'b0;
        if (rv && ra != 0) pend[ra] = 1'b1;
        m_we = 1'b0;
        if (g0) begin
            pref = 1;
            if (a0 != 0) begin m_we = 1'b1; m_a3 = a0; m_wd3 = d0; end
        end else if (g1) begin
            pref = 0;
            if (a1 != 0) begin m_we = 1'b1; m_a3 = a1; m_wd3 = d1; end
        end
        #1;
        chk("we3", {63'd0, bus.WE3}, {63'd0, m_we});
        chk("a3", {59'd0, bus.A3}, {59'd0, m_a3});
        chk("wd3", {32'd0, bus.WD3}, {32'd0, m_wd3});
    endtask

    task automatic idle_inputs();
        bus.wb_hold   = 1'b0;
        bus.r0_valid  = 1'b0; bus.r0_addr = '0; bus.r0_data = '0;
        bus.r1_valid  = 1'b0; bus.r1_addr = '0; bus.r1_data = '0;
        bus.rsv_valid = 1'b0; bus.rsv_addr = '0;
        bus.q_a1      = '0;   bus.q_a2 = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.r0_valid = 1'b1;
        bus.r1_valid = 1'b1;
        do_reset();
        idle_inputs();

        // Single request from req0
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd5; bus.r0_data = 32'hDEADBEEF;
        step();
        chk("t1_we3", {63'd0, bus.WE3}, 64'd1);
        chk("t1_a3", {59'd0, bus.A3}, 64'd5);
        chk("t1_wd3", {32'd0, bus.WD3}, 64'hDEADBEEF);
        bus.r0_valid = 1'b0;
        step();
        chk("t1_we3_off", {63'd0, bus.WE3}, 64'd0);

        // Both contend for four cycles: alternate starting with req0
        do_reset();
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd1; bus.r0_data = 32'h1111;
        bus.r1_valid = 1'b1; bus.r1_addr = 5'd2; bus.r1_data = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_we3", {63'd0, bus.WE3}, 64'd1);
            chk("t2_a3", {59'd0, bus.A3}, (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        step();

        // Hold blocks grants and leaves the pointer alone
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1; bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_we3_hold", {63'd0, bus.WE3}, 64'd0);
        end
        bus.wb_hold = 1'b0;
        step();
        chk("t3_first_a3", {59'd0, bus.A3}, 64'd1);
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        step();

        // Scoreboard around a write to r7, including same-edge re-reservation
        bus.q_a1 = 5'd7;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
        step();
        chk("t4_busy_set", {63'd0, bus.q_busy1}, 64'd1);
        bus.rsv_valid = 1'b0;
        bus.r1_valid = 1'b1; bus.r1_addr = 5'd7; bus.r1_data = 32'h7777;
        step();
        chk("t4_busy_we", {63'd0, bus.q_busy1}, {63'd0, !FWD});
        bus.r1_valid = 1'b0;
        bus.rsv_valid = 1'b1;
        step();
        chk("t4_busy_rersv", {63'd0, bus.q_busy1}, 64'd1);
        bus.rsv_valid = 1'b0;
        bus.r1_valid = 1'b1; bus.r1_data = 32'h7778;
        step();
        bus.r1_valid = 1'b0;
        step();
        chk("t4_busy_clr", {63'd0, bus.q_busy1}, 64'd0);

        // Register 0 write consumes its slot without a write pulse
        do_reset();
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd0; bus.r0_data = 32'h1234;
        bus.r1_valid = 1'b1; bus.r1_addr = 5'd3; bus.r1_data = 32'h3333;
        step();
        chk("t5_we3_r0", {63'd0, bus.WE3}, 64'd0);
        bus.r0_addr = 5'd4; bus.r0_data = 32'h4444;
        step();
        chk("t5_next_a3", {59'd0, bus.A3}, 64'd3);
        bus.r1_valid = 1'b0;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0; bus.q_a1 = 5'd0;
        step();
        bus.r0_valid = 1'b0; bus.rsv_valid = 1'b0;
        step();
        chk("t5_busy_r0", {63'd0, bus.q_busy1}, 64'd0);

        // Write to r9 with forwarding view, then reset during the write cycle
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9; bus.q_a2 = 5'd9;
        step();
        bus.rsv_valid = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd9; bus.r0_data = 32'hA5A5A5A5;
        step();
        bus.r0_valid = 1'b0;
        chk("t6_we3", {63'd0, bus.WE3}, 64'd1);
`ifdef REGFILE_WB_FWD_EN
        chk("t6_fwd_hit2", {63'd0, bus.fwd_hit2}, 64'd1);
        chk("t6_fwd_data2", {32'd0, bus.fwd_data2}, 64'hA5A5A5A5);
        chk("t6_busy2", {63'd0, bus.q_busy2}, 64'd0);
`else
        chk("t6_busy2", {63'd0, bus.q_busy2}, 64'd1);
`endif
        do_reset();
        idle_inputs();

        // Randomized traffic with protocol-correct requesters
        for (int i = 0; i < 400; i++) begin
            if (!bus.r0_valid || g0) begin
                bus.r0_valid = ($urandom_range(0, 9) < 6);
                bus.r0_addr  = 5'($urandom_range(0, 7));
                bus.r0_data  = $urandom;
            end
            if (!bus.r1_valid || g1) begin
                bus.r1_valid = ($urandom_range(0, 9) < 6);
                bus.r1_addr  = 5'($urandom_range(0, 7));
                bus.r1_data  = $urandom;
            end
            bus.wb_hold   = ($urandom_range(0, 9) < 2);
            bus.rsv_valid = ($urandom_range(0, 9) < 3);
            bus.rsv_addr  = 5'($urandom_range(0, 7));
            bus.q_a1      = 5'($urandom_range(0, 7));
            bus.q_a2      = 5'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
